// File: rtl/simple_multiplier.sv
// Sequential signed WIDTHxWIDTH multiplier, radix-2 Booth, one partial product per clock.
// Latency WIDTH edges after accept; start is ignored while busy, and product holds until the next completion.
module simple_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]         r_state;
  logic [WIDTH:0]     r_a;
  logic [WIDTH-1:0]   r_q;
  logic               r_qm1;
  logic [WIDTH-1:0]   r_m;
  logic [CW-1:0]      r_cnt;
  logic               r_done;
  logic [2*WIDTH-1:0] r_product;

  logic [WIDTH:0]     w_m_ext;
  logic [WIDTH:0]     w_a_sum;
  logic [WIDTH:0]     w_a_nxt;
  logic [WIDTH-1:0]   w_q_nxt;
  logic               w_last;

  // The extra accumulator bit keeps x = -2^(WIDTH-1) exact when it is subtracted.
  always_comb begin
    w_m_ext = {r_m[WIDTH-1], r_m};
    w_a_sum = r_a;
    case ({r_q[0], r_qm1})
      2'b01:   w_a_sum = r_a + w_m_ext;
      2'b10:   w_a_sum = r_a - w_m_ext;
      default: w_a_sum = r_a;
    endcase
    w_a_nxt = {w_a_sum[WIDTH], w_a_sum[WIDTH:1]};
    w_q_nxt = {w_a_sum[0], r_q[WIDTH-1:1]};
    w_last  = (r_cnt == CW'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_q       <= '0;
      r_qm1     <= 1'b0;
      r_m       <= '0;
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_m     <= x;
            r_q     <= y;
            r_qm1   <= 1'b0;
            r_a     <= '0;
            r_cnt   <= CW'(WIDTH);
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_a   <= w_a_nxt;
          r_q   <= w_q_nxt;
          r_qm1 <= r_q[0];
          r_cnt <= r_cnt - CW'(1);
          if (w_last) begin
            r_product <= {w_a_nxt[WIDTH-1:0], w_q_nxt};
            r_done    <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy    = (r_state == S_RUN);
  assign done    = r_done;
  assign product = r_product;

endmodule

// File: tb/tb_simple_multiplier.sv
// Bench for simple_multiplier: directed table, handshake corner cases, and random operands against a.b arithmetic.
module tb_simple_multiplier;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] x;
  logic [31:0] y;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int     n_vec;
  int     n_err;
  longint prev_prod;

  simple_multiplier #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .x       (x),
    .y       (y),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    longint      e;
  } vec_t;

  vec_t tbl[9];

  function automatic longint ref_mul(input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return sa * sb;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h, expected 0x%h", nm, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle (or in its done cycle); returns at the negedge where done is seen.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input longint e,
                       input string nm, input int inj);
    int lat;
    int bad_busy;
    int bad_hold;
    lat      = -1;
    bad_busy = 0;
    bad_hold = 0;
    start = 1'b1;
    x     = a;
    y     = b;
    @(negedge clk);
    start = 1'b0;
    x     = $urandom;
    y     = $urandom;
    chk({nm, " busy after accept"}, {63'd0, busy}, 64'd1);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
      if (!busy) bad_busy++;
      if ($signed(product) != prev_prod) bad_hold++;
      if (k == inj) begin
        start = 1'b1;
        x     = $urandom;
        y     = $urandom;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk({nm, " latency"}, 64'(lat), 64'd32);
    chk({nm, " product"}, product, e);
    chk({nm, " busy low at done"}, {63'd0, busy}, 64'd0);
    chk({nm, " busy gaps/hold"}, 64'(bad_busy + bad_hold), 64'd0);
    prev_prod = e;
  endtask

  task automatic quiet(input int n, input string nm);
    int pulses;
    pulses = 0;
    start  = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk({nm, " no stray done"}, 64'(pulses), 64'd0);
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    prev_prod = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    x         = '0;
    y         = '0;

    tbl[0] = '{32'd2,          -32'sd5,       -64'sd10};
    tbl[1] = '{32'd12,         32'd5,         64'sd60};
    tbl[2] = '{-32'sd20,       -32'sd11,      64'sd220};
    tbl[3] = '{-32'sd3,        32'd21,        -64'sd63};
    tbl[4] = '{32'd100,        32'd0,         64'sd0};
    tbl[5] = '{32'd65535,      32'd1,         64'sd65535};
    tbl[6] = '{-32'sd4,        32'h8000_0000, 64'sd8589934592};
    tbl[7] = '{32'h7fff_ffff,  32'h8000_0000, -64'sd4611686016279904256};
    tbl[8] = '{32'h8000_0000,  32'h8000_0000, 64'sd4611686018427387904};

    #3;
    chk("reset busy", {63'd0, busy}, 64'd0);
    chk("reset done", {63'd0, done}, 64'd0);
    chk("reset product", product, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      do_op(tbl[i].a, tbl[i].b, tbl[i].e, $sformatf("tbl%0d", i), -1);
      @(negedge clk);
      chk($sformatf("tbl%0d done single-cycle", i), {63'd0, done}, 64'd0);
    end

    // Second start mid-operation must be dropped, not queued.
    do_op(32'd7, 32'd9, 64'sd63, "start-while-busy", 12);
    quiet(40, "start-while-busy");
    chk("start-while-busy product held", product, 64'd63);

    // Back-to-back: next start lands in the done cycle.
    do_op(32'd1000, -32'sd3, -64'sd3000, "b2b first", -1);
    do_op(-32'sd77, 32'd77, -64'sd5929, "b2b second", -1);
    @(negedge clk);

    // Asynchronous reset between edges, partway through an operation.
    start = 1'b1;
    x     = 32'd123456;
    y     = 32'd654321;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst busy", {63'd0, busy}, 64'd0);
    chk("async rst done", {63'd0, done}, 64'd0);
    chk("async rst product", product, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    prev_prod = 0;
    quiet(40, "after abort");
    chk("after abort product", product, 64'd0);
    do_op(32'd6, -32'sd7, -64'sd42, "post-reset op", -1);
    @(negedge clk);

    for (int i = 0; i < 30; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      if ($urandom_range(0, 7) == 0) b = 32'h8000_0000;
      do_op(a, b, ref_mul(a, b), $sformatf("rand%0d", i), -1);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/simple_multiplier.md
Name: simple_multiplier

Overview:
Sequential signed 32x32 -> 64-bit multiplier using radix-2 Booth recoding, one partial product per clock. It is the baseline multiplier of the arithmetic library and is used wherever area matters more than latency. It uses a start/busy/done handshake and holds the last result until the next operation completes.

Parameters:
WIDTH, 32, operand width in bits; product is 2*WIDTH bits; iteration count equals WIDTH.

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
start  input  1  request to begin a multiply; sampled on rising clk
x  input  WIDTH  multiplicand, two's complement signed
y  input  WIDTH  multiplier, two's complement signed
busy  output  1  high while an operation is in progress
done  output  1  single-cycle pulse when product is updated
product  output  2*WIDTH  signed result x*y, registered

Behaviour:
- Reset (rst_n low, asynchronous): busy=0, done=0, product=0, internal accumulator/counter cleared. Reset takes effect immediately and does not wait for a clock edge.
- Reset during an operation aborts it. No done pulse is generated and product reads 0.
- States: IDLE and RUN.
- IDLE: on a rising edge with start=1, capture x and y into internal registers, clear the accumulator, load counter=WIDTH, set busy=1, and go to RUN.
- x and y are sampled only at the accept edge and may change freely afterwards.
- RUN: each edge performs one Booth step:
  - examine multiplier bits {q0, q-1};
  - 01 adds the sign-extended multiplicand to the upper half; 10 subtracts it; 00/11 leave it unchanged;
  - then arithmetic-shift-right the {A, Q, q-1} register;
  - decrement the counter.
- The upper-half add/subtract uses a WIDTH+1-bit signed accumulator. This is required so that x = -2^(WIDTH-1) is handled without overflow.
- On the edge that completes step WIDTH:
  - product <= {A, Q} as an exact signed 2*WIDTH result;
  - done=1 for exactly one cycle;
  - busy=0;
  - return to IDLE.
- Latency: done and the new product become visible WIDTH clock edges after the accept edge (32 cycles with the default).
- start while busy=1 is ignored; it is not queued.
- start=1 in the cycle where done=1 is accepted, because busy is already 0 in that cycle. This gives back-to-back operations every WIDTH+1 cycles.
- product holds its value between completions. done is 0 at all times other than the completion cycle.
- The result is exact for every operand pair, including (-2^31)*(-2^31) = 2^62. Overflow cannot occur.
- start held high continuously launches a new operation each time the block returns to IDLE.

Test Plan:
- Reset, then x=2, y=-5, start pulse -> done pulses exactly 32 cycles after the accept edge with product=-10; busy is high throughout.
- Sign combinations, one operation each: 12*5 -> 60; -20*-11 -> 220; -3*21 -> -63; 100*0 -> 0; 65535*1 -> 65535.
- Extremes:
  - -4 * -2147483648 -> 8589934592;
  - 2147483647 * -2147483648 -> -4611686016279904256;
  - -2147483648 * -2147483648 -> 4611686018427387904.
- Start while busy: issue a second start with different operands mid-operation -> it is ignored; the first result is unchanged and exactly one done pulse occurs.
- Back-to-back: assert start in the done cycle with new operands -> the next done follows 32 cycles later with the correct new product; the previous product holds in between.
- Async reset mid-operation: drop rst_n at cycle 10 without a clock edge -> busy, done and product go to 0 immediately; no done pulse afterwards; a subsequent start works normally.
